wb_master_mux: RTL and testbench

Shared-bus master multiplexer that sits directly downstream of the five-way round-robin Wishbone arbiter. It presents the masters' cycle requests to the arbiter and latches the arbiter's one-hot grant into a bus owner. It then routes the owner's address, data and control onto the single shared slave bus, and returns acknowledge and error to the owner only. An optional watchdog terminates stalled cycles with an error.

---
 rtl/wb_bus_pkg.sv | 21 ++
 rtl/wb_bus_watchdog.sv | 22 ++
 rtl/wb_master_mux.sv | 87 ++++++++
 tb/tb_wb_master_mux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// wb_bus_pkg: shared constants, state encoding and grant decoding for the Wishbone master mux
package wb_bus_pkg;
  localparam int NUM_MASTERS = 5;
  localparam int MIDX_W = 3;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;
  typedef struct packed {
    logic              valid;
    logic [MIDX_W-1:0] idx;
  } oh_idx_t;
  function automatic oh_idx_t onehot_to_idx(input logic [NUM_MASTERS-1:0] v);
    oh_idx_t r;
    r.valid = $onehot(v);
    r.idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) if (v[i]) r.idx = MIDX_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/wb_bus_watchdog.sv
// wb_bus_watchdog: counts consecutive stalled strobe cycles and flags the terminal count
module wb_bus_watchdog #(
  parameter int TO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // terminal count only fires on a still-stalled cycle, so a late ack/err wins
  always_comb begin
    tc = run && (cnt_q == CW'(TO_CYCLES));
    cnt_d = (run && !tc) ? cnt_q + CW'(1) : '0;
  end
  // stall counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_master_mux.sv
// wb_master_mux: latches the arbiter grant and routes the owning master onto the shared bus; WB_MUX_TIMEOUT_EN adds a stall watchdog
module wb_master_mux
  import wb_bus_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [NUM_MASTERS-1:0]      rqst_o,
  input  logic [NUM_MASTERS-1:0]      gnt_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i
);
  localparam int SW = DW / 8;
  state_t                 state_q, state_d;
  logic [MIDX_W-1:0]      own_q, own_d;
  logic [NUM_MASTERS-1:0] own_oh;
  oh_idx_t                gi;
  logic                   owned, tmo, own_cyc, take, run, tc;
  assign rqst_o  = m_cyc_i;
  assign m_dat_o = s_dat_i;
  assign run     = s_stb_o & ~s_ack_i & ~s_err_i;
  // route the owner onto the slave bus and steer the response back to it alone
  always_comb begin
    owned   = state_q == ST_OWNED;
    tmo     = state_q == ST_TIMEOUT;
    own_cyc = m_cyc_i[own_q];
    own_oh  = NUM_MASTERS'(1) << own_q;
    s_cyc_o = owned & own_cyc;
    s_stb_o = s_cyc_o & m_stb_i[own_q];
    s_we_o  = owned & m_we_i[own_q];
    s_adr_o = owned ? m_adr_i[int'(own_q)*AW +: AW] : '0;
    s_dat_o = owned ? m_dat_i[int'(own_q)*DW +: DW] : '0;
    s_sel_o = owned ? m_sel_i[int'(own_q)*SW +: SW] : '0;
    m_ack_o = (owned && s_ack_i) ? own_oh : '0;
    m_err_o = ((owned && s_err_i) || tmo) ? own_oh : '0;
  end
  // take ownership on a clean one-hot grant, hold it until the owner drops cyc or stalls out
  always_comb begin
    gi      = onehot_to_idx(gnt_i);
    take    = state_q == ST_IDLE && gi.valid && m_cyc_i[gi.idx];
    own_d   = take ? gi.idx : own_q;
    state_d = take ? ST_OWNED
            : state_q == ST_OWNED ? (!m_cyc_i[own_q] ? ST_IDLE : tc ? ST_TIMEOUT : ST_OWNED)
            : ST_IDLE;
  end
  // state and owner registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end
`ifdef WB_MUX_TIMEOUT_EN
  wb_bus_watchdog #(.TO_CYCLES(TO_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .run(run),
    .tc (tc)
  );
`else
  logic unused_wdog;
  assign tc = 1'b0;
  assign unused_wdog = run & (TO_CYCLES > 0);
`endif
endmodule

// File: tb/tb_wb_master_mux.sv
// tb_wb_master_mux: directed and randomized checks of wb_master_mux against a behavioural bus-ownership model
module tb_wb_master_mux;
  localparam int AW = 32, DW = 32, SW = DW / 8, N = 5, TO = 4;
`ifdef WB_MUX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] rqst_o, gnt_i, m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  int errors = 0, checks = 0, cyc_n = 0;
  bit busy = 1'b0, tmo = 1'b0;
  int own = 0, stall = 0;

  always #5 clk = ~clk;

  wb_master_mux #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rqst_o(rqst_o), .gnt_i(gnt_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // compare every DUT output against what the ownership model says this cycle should show
  task automatic settle();
    logic [N-1:0] oh;
    logic c;
    #1;
    oh = (busy || tmo) ? N'(1) << own : '0;
    c = busy && m_cyc_i[own];
    chk("rqst", rqst_o, m_cyc_i);
    chk("m_dat", m_dat_o, s_dat_i);
    chk("s_cyc", s_cyc_o, c);
    chk("s_stb", s_stb_o, c && m_stb_i[own]);
    chk("s_we", s_we_o, busy && m_we_i[own]);
    chk("s_adr", s_adr_o, busy ? m_adr_i[own*AW +: AW] : '0);
    chk("s_dat", s_dat_o, busy ? m_dat_i[own*DW +: DW] : '0);
    chk("s_sel", s_sel_o, busy ? m_sel_i[own*SW +: SW] : '0);
    chk("m_ack", m_ack_o, (busy && s_ack_i) ? oh : '0);
    chk("m_err", m_err_o, ((busy && s_err_i) || tmo) ? oh : '0);
  endtask

  // advance one clock and update the model from the inputs seen at that edge
  task automatic tick();
    bit stalled;
    stalled = busy && m_cyc_i[own] && m_stb_i[own] && !s_ack_i && !s_err_i;
    @(posedge clk);
    if (rst) begin
      busy = 0; tmo = 0; own = 0; stall = 0;
    end else if (tmo) tmo = 0;
    else if (!busy) begin
      if ($countones(gnt_i) == 1 && (m_cyc_i & gnt_i) != 0) begin
        busy = 1; own = $clog2(gnt_i); stall = 0;
      end
    end else if (!m_cyc_i[own]) begin
      busy = 0; stall = 0;
    end else if (stalled && TO_EN && stall == TO) begin
      busy = 0; tmo = 1; stall = 0;
    end else stall = stalled ? stall + 1 : 0;
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_all();
    m_cyc_i = '0; m_stb_i = '0; gnt_i = '0; s_ack_i = 0; s_err_i = 0;
  endtask

  initial begin
    int r;
    bit silent;
    silent = 0;
    idle_all();
    m_we_i = '0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; s_dat_i = 32'h5A5A_0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 0;

    // single grant: master 2, ack in cycle 3
    m_cyc_i[2] = 1; m_stb_i[2] = 1; m_we_i[2] = 1; m_adr_i[2*AW +: AW] = 32'h1000; gnt_i = 5'b00100;
    settle(); chk("sg_c0_cyc", s_cyc_o, 0); tick();
    gnt_i = '0;
    for (int k = 1; k <= 4; k++) begin
      s_ack_i = (k == 3);
      settle();
      chk("sg_cyc", s_cyc_o, 1);
      chk("sg_adr", s_adr_o, 32'h1000);
      chk("sg_ack", m_ack_o, k == 3 ? 5'b00100 : 5'b00000);
      tick();
    end
    s_ack_i = 0; m_cyc_i[2] = 0; m_stb_i[2] = 0;
    settle(); chk("sg_drop", s_cyc_o, 0); tick();
    settle(); chk("sg_idle", s_cyc_o, 0); tick();

    // locked bus: grant moves to master 3 while master 0 owns
    m_cyc_i[0] = 1; m_stb_i[0] = 1; m_adr_i[0*AW +: AW] = 32'hA0; m_adr_i[3*AW +: AW] = 32'hB0;
    gnt_i = 5'b00001; s_ack_i = 1;
    step();
    gnt_i = 5'b01000; m_cyc_i[3] = 1; m_stb_i[3] = 1;
    for (int k = 1; k <= 3; k++) begin
      settle(); chk("lk_adr", s_adr_o, 32'hA0); chk("lk_ack", m_ack_o, 5'b00001); tick();
    end
    m_cyc_i[0] = 0; m_stb_i[0] = 0;
    settle(); chk("lk_drop", s_cyc_o, 0); tick();
    settle(); chk("lk_gap", s_cyc_o, 0); tick();
    settle(); chk("lk_m3", s_adr_o, 32'hB0); chk("lk_m3ack", m_ack_o, 5'b01000); tick();
    idle_all(); step(); step();

    // bad grants are ignored
    m_cyc_i = 5'b00110; m_stb_i = 5'b00110; gnt_i = 5'b00110;
    repeat (2) begin settle(); chk("bg_multi", s_cyc_o, 0); tick(); end
    gnt_i = '0;
    repeat (2) begin settle(); chk("bg_zero", s_cyc_o, 0); tick(); end
    idle_all(); step();

`ifdef WB_MUX_TIMEOUT_EN
    // stalled slave: one-cycle error after TO+1 stalled strobes
    m_cyc_i[4] = 1; m_stb_i[4] = 1; gnt_i = 5'b10000;
    step();
    gnt_i = '0;
    for (int k = 1; k <= 5; k++) begin
      settle(); chk("to_noerr", m_err_o, 0); chk("to_stb", s_stb_o, 1); tick();
    end
    settle(); chk("to_err", m_err_o, 5'b10000); chk("to_stbz", s_stb_o, 0); chk("to_cycz", s_cyc_o, 0); tick();
    settle(); chk("to_idle", s_cyc_o, 0); chk("to_err1", m_err_o, 0); tick();
    // ack on the terminal cycle beats the timeout
    gnt_i = 5'b10000;
    step();
    gnt_i = '0;
    for (int k = 1; k <= 5; k++) begin
      s_ack_i = (k == 5);
      settle(); chk("ta_ack", m_ack_o, k == 5 ? 5'b10000 : 5'b00000); tick();
    end
    s_ack_i = 0;
    settle(); chk("ta_noerr", m_err_o, 0); chk("ta_own", s_cyc_o, 1); tick();
    idle_all(); step(); step();
`endif

    // reset while owned drops everything on the next cycle
    m_cyc_i[1] = 1; m_stb_i[1] = 1; m_adr_i[1*AW +: AW] = 32'hC0; gnt_i = 5'b00010;
    step();
    gnt_i = '0;
    step();
    rst = 1;
    step();
    rst = 0; s_ack_i = 1; s_err_i = 1;
    settle();
    chk("rst_cyc", s_cyc_o, 0); chk("rst_stb", s_stb_o, 0); chk("rst_adr", s_adr_o, 0);
    chk("rst_ack", m_ack_o, 0); chk("rst_err", m_err_o, 0);
    tick();
    s_ack_i = 0; s_err_i = 0; gnt_i = 5'b00010;
    step();
    gnt_i = '0;
    repeat (8) step();
    idle_all(); step();

    // randomized traffic
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 29) == 0) silent = !silent;
      for (int i = 0; i < N; i++) begin
        if (m_cyc_i[i]) begin
          if ($urandom_range(0, 7) == 0) m_cyc_i[i] = 0;
        end else if ($urandom_range(0, 3) == 0) m_cyc_i[i] = 1;
        m_stb_i[i] = $urandom_range(0, 3) != 0;
        m_we_i[i] = 1'($urandom);
        m_adr_i[i*AW +: AW] = $urandom;
        m_dat_i[i*DW +: DW] = $urandom;
        m_sel_i[i*SW +: SW] = SW'($urandom);
      end
      r = int'($urandom_range(0, 99));
      gnt_i = r < 70 ? N'(1) << $urandom_range(0, N-1) : r < 85 ? '0 : N'($urandom);
      s_ack_i = !silent && $urandom_range(0, 2) == 0;
      s_err_i = !silent && $urandom_range(0, 11) == 0;
      s_dat_i = $urandom;
      rst = $urandom_range(0, 149) == 0;
      step();
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
